// File: rtl/cv32e40x_xif_offload_ctrl.sv
// cv32e40x_xif_offload_ctrl
//   Core-side initiator of the eXtension interface. Takes offload requests
//   from ID into a one-deep issue slot, drives the issue channel, allocates
//   ids, tracks outstanding instructions in an in-order scoreboard, drives
//   the commit channel (commit or kill) and converts results into
//   register-file writes.
// Ports
//   off_*         : offload request from ID and accept/illegal pulses back
//   commit_go_i   : oldest uncommitted entry is non-speculative
//   kill_i        : flush every uncommitted entry (and the pending slot)
//   xif_issue_*   : issue request/response channel
//   xif_commit_*  : registered commit strobe, id and kill flag
//   xif_result_*  : result channel
//   rf_*          : registered register-file write port
//   busy_o        : issue slot or any scoreboard entry occupied
module cv32e40x_xif_offload_ctrl #(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned X_RFR_WIDTH     = 32,
    parameter int unsigned X_NUM_RS        = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            off_valid_i,
    output logic                            off_ready_o,
    input  logic [31:0]                     off_instr_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] off_rs_i,
    input  logic [X_NUM_RS-1:0]             off_rs_valid_i,
    output logic                            off_accept_o,
    output logic                            off_illegal_o,
    input  logic                            commit_go_i,
    input  logic                            kill_i,
    output logic                            xif_issue_valid_o,
    input  logic                            xif_issue_ready_i,
    output logic [31:0]                     xif_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]           xif_issue_id_o,
    output logic [X_NUM_RS*X_RFR_WIDTH-1:0] xif_issue_rs_o,
    output logic [X_NUM_RS-1:0]             xif_issue_rs_valid_o,
    input  logic                            xif_issue_accept_i,
    input  logic                            xif_issue_writeback_i,
    output logic                            xif_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]           xif_commit_id_o,
    output logic                            xif_commit_kill_o,
    input  logic                            xif_result_valid_i,
    output logic                            xif_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]           xif_result_id_i,
    input  logic [X_RFR_WIDTH-1:0]          xif_result_data_i,
    input  logic [4:0]                      xif_result_rd_i,
    input  logic                            xif_result_we_i,
    output logic                            rf_we_o,
    output logic [4:0]                      rf_waddr_o,
    output logic [X_RFR_WIDTH-1:0]          rf_wdata_o,
    output logic                            busy_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    typedef logic [CW-1:0] cnt_t;

    // Issue slot
    logic                            slot_full_q, slot_full_d;
    logic                            slot_killed_q, slot_killed_d;
    logic [31:0]                     slot_instr_q, slot_instr_d;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] slot_rs_q, slot_rs_d;
    logic [X_NUM_RS-1:0]             slot_rs_valid_q, slot_rs_valid_d;
    logic [X_ID_WIDTH-1:0]           id_cnt_q, id_cnt_d;

    // Scoreboard, kept compacted: entry 0 is the oldest
    logic [MAX_OUTSTANDING-1:0]                 ent_vld_q, ent_vld_d;
    logic [MAX_OUTSTANDING-1:0][X_ID_WIDTH-1:0] ent_id_q, ent_id_d;
    logic [MAX_OUTSTANDING-1:0]                 ent_wb_q, ent_wb_d;
    logic [MAX_OUTSTANDING-1:0]                 ent_cmt_q, ent_cmt_d;
    logic [MAX_OUTSTANDING-1:0]                 ent_kill_q, ent_kill_d;

    // Registered outputs
    logic                   commit_valid_q, commit_valid_d;
    logic [X_ID_WIDTH-1:0]  commit_id_q, commit_id_d;
    logic                   commit_kill_q, commit_kill_d;
    logic                   accept_q, accept_d;
    logic                   illegal_q, illegal_d;
    logic                   rf_we_q, rf_we_d;
    logic [4:0]             rf_waddr_q, rf_waddr_d;
    logic [X_RFR_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    // Combinational helpers
    cnt_t                             cnt, nsurv;
    cnt_t [MAX_OUTSTANDING-1:0]       pos;
    logic [MAX_OUTSTANDING-1:0]       kill_n, cmt_n, free, surv, res_sel;
    logic                             found, res_hold, issue_hs, off_hs, res_hs;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_vld_q[i]) cnt = cnt + cnt_t'(1);
        end

        off_ready_o = !slot_full_q && (cnt < cnt_t'(MAX_OUTSTANDING));
        off_hs      = off_valid_i && off_ready_o;
        issue_hs    = slot_full_q && xif_issue_ready_i;

        // Issue slot
        slot_full_d     = slot_full_q;
        slot_killed_d   = slot_killed_q;
        slot_instr_d    = slot_instr_q;
        slot_rs_d       = slot_rs_q;
        slot_rs_valid_d = slot_rs_valid_q;
        if (kill_i && slot_full_q) slot_killed_d = 1'b1;
        if (issue_hs) begin
            slot_full_d   = 1'b0;
            slot_killed_d = 1'b0;
        end
        if (off_hs) begin
            slot_full_d     = 1'b1;
            slot_killed_d   = 1'b0;
            slot_instr_d    = off_instr_i;
            slot_rs_d       = off_rs_i;
            slot_rs_valid_d = off_rs_valid_i;
        end
        id_cnt_d  = issue_hs ? id_cnt_q + X_ID_WIDTH'(1) : id_cnt_q;
        accept_d  = issue_hs && xif_issue_accept_i;
        illegal_d = issue_hs && !xif_issue_accept_i;

        // Commit: only the oldest uncommitted entry is considered. kill_i
        // marks it killed in the same cycle, which is how it beats commit_go_i.
        kill_n         = ent_kill_q | ({MAX_OUTSTANDING{kill_i}} & ent_vld_q & ~ent_cmt_q);
        cmt_n          = ent_cmt_q;
        free           = '0;
        found          = 1'b0;
        commit_valid_d = 1'b0;
        commit_id_d    = '0;
        commit_kill_d  = 1'b0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!found && ent_vld_q[i] && !ent_cmt_q[i]) begin
                found = 1'b1;
                if (kill_n[i]) begin
                    commit_valid_d = 1'b1;
                    commit_kill_d  = 1'b1;
                    commit_id_d    = ent_id_q[i];
                    free[i]        = 1'b1;
                end else if (commit_go_i) begin
                    commit_valid_d = 1'b1;
                    commit_id_d    = ent_id_q[i];
                    cmt_n[i]       = 1'b1;
                    if (!ent_wb_q[i]) free[i] = 1'b1;
                end
            end
        end

        // Result: held off while its entry is still speculative; a killed
        // entry's result is swallowed and the kill commit frees the entry.
        res_hold = 1'b0;
        res_sel  = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_vld_q[i] && (ent_id_q[i] == xif_result_id_i)) begin
                if (ent_cmt_q[i]) res_sel[i] = 1'b1;
                else if (!ent_kill_q[i]) res_hold = 1'b1;
            end
        end
        xif_result_ready_o = !(xif_result_valid_i && res_hold);
        res_hs     = xif_result_valid_i && xif_result_ready_o;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (res_hs && (res_sel != '0)) begin
            free = free | res_sel;
            if (xif_result_we_i) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = xif_result_rd_i;
                rf_wdata_d = xif_result_data_i;
            end
        end

        // Compact survivors towards entry 0, then append the newly issued
        // entry behind them so age order is preserved by position.
        surv  = ent_vld_q & ~free;
        nsurv = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            pos[i] = nsurv;
            if (surv[i]) nsurv = nsurv + cnt_t'(1);
        end
        ent_vld_d  = '0;
        ent_id_d   = '0;
        ent_wb_d   = '0;
        ent_cmt_d  = '0;
        ent_kill_d = '0;
        for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (surv[i] && (pos[i] == cnt_t'(j))) begin
                    ent_vld_d[j]  = 1'b1;
                    ent_id_d[j]   = ent_id_q[i];
                    ent_wb_d[j]   = ent_wb_q[i];
                    ent_cmt_d[j]  = cmt_n[i];
                    ent_kill_d[j] = kill_n[i];
                end
            end
            if (issue_hs && (nsurv == cnt_t'(j))) begin
                ent_vld_d[j]  = 1'b1;
                ent_id_d[j]   = id_cnt_q;
                ent_wb_d[j]   = xif_issue_writeback_i;
                ent_cmt_d[j]  = 1'b0;
                ent_kill_d[j] = slot_killed_q || kill_i || !xif_issue_accept_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_q     <= 1'b0;
            slot_killed_q   <= 1'b0;
            slot_instr_q    <= '0;
            slot_rs_q       <= '0;
            slot_rs_valid_q <= '0;
            id_cnt_q        <= '0;
            ent_vld_q       <= '0;
            ent_id_q        <= '0;
            ent_wb_q        <= '0;
            ent_cmt_q       <= '0;
            ent_kill_q      <= '0;
            commit_valid_q  <= 1'b0;
            commit_id_q     <= '0;
            commit_kill_q   <= 1'b0;
            accept_q        <= 1'b0;
            illegal_q       <= 1'b0;
            rf_we_q         <= 1'b0;
            rf_waddr_q      <= '0;
            rf_wdata_q      <= '0;
        end else begin
            slot_full_q     <= slot_full_d;
            slot_killed_q   <= slot_killed_d;
            slot_instr_q    <= slot_instr_d;
            slot_rs_q       <= slot_rs_d;
            slot_rs_valid_q <= slot_rs_valid_d;
            id_cnt_q        <= id_cnt_d;
            ent_vld_q       <= ent_vld_d;
            ent_id_q        <= ent_id_d;
            ent_wb_q        <= ent_wb_d;
            ent_cmt_q       <= ent_cmt_d;
            ent_kill_q      <= ent_kill_d;
            commit_valid_q  <= commit_valid_d;
            commit_id_q     <= commit_id_d;
            commit_kill_q   <= commit_kill_d;
            accept_q        <= accept_d;
            illegal_q       <= illegal_d;
            rf_we_q         <= rf_we_d;
            rf_waddr_q      <= rf_waddr_d;
            rf_wdata_q      <= rf_wdata_d;
        end
    end

    assign xif_issue_valid_o    = slot_full_q;
    assign xif_issue_instr_o    = slot_instr_q;
    assign xif_issue_id_o       = id_cnt_q;
    assign xif_issue_rs_o       = slot_rs_q;
    assign xif_issue_rs_valid_o = slot_rs_valid_q;
    assign xif_commit_valid_o   = commit_valid_q;
    assign xif_commit_id_o      = commit_id_q;
    assign xif_commit_kill_o    = commit_kill_q;
    assign off_accept_o         = accept_q;
    assign off_illegal_o        = illegal_q;
    assign rf_we_o              = rf_we_q;
    assign rf_waddr_o           = rf_waddr_q;
    assign rf_wdata_o           = rf_wdata_q;
    assign busy_o               = slot_full_q || (cnt != '0);

endmodule

// File: tb/tb_cv32e40x_xif_offload_ctrl.sv
// Directed testbench for cv32e40x_xif_offload_ctrl with commit and
// register-file write scoreboards.
module tb_cv32e40x_xif_offload_ctrl;

    localparam int unsigned IDW  = 4;
    localparam int unsigned RW   = 32;
    localparam int unsigned NRS  = 2;
    localparam int unsigned MAXO = 2;

    logic              clk, rst_n;
    logic              off_valid_i, off_ready_o;
    logic [31:0]       off_instr_i;
    logic [NRS*RW-1:0] off_rs_i;
    logic [NRS-1:0]    off_rs_valid_i;
    logic              off_accept_o, off_illegal_o;
    logic              commit_go_i, kill_i;
    logic              xif_issue_valid_o, xif_issue_ready_i;
    logic [31:0]       xif_issue_instr_o;
    logic [IDW-1:0]    xif_issue_id_o;
    logic [NRS*RW-1:0] xif_issue_rs_o;
    logic [NRS-1:0]    xif_issue_rs_valid_o;
    logic              xif_issue_accept_i, xif_issue_writeback_i;
    logic              xif_commit_valid_o;
    logic [IDW-1:0]    xif_commit_id_o;
    logic              xif_commit_kill_o;
    logic              xif_result_valid_i, xif_result_ready_o;
    logic [IDW-1:0]    xif_result_id_i;
    logic [RW-1:0]     xif_result_data_i;
    logic [4:0]        xif_result_rd_i;
    logic              xif_result_we_i;
    logic              rf_we_o;
    logic [4:0]        rf_waddr_o;
    logic [RW-1:0]     rf_wdata_o;
    logic              busy_o;

    cv32e40x_xif_offload_ctrl #(
        .X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .X_NUM_RS(NRS), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .off_valid_i(off_valid_i), .off_ready_o(off_ready_o),
        .off_instr_i(off_instr_i), .off_rs_i(off_rs_i), .off_rs_valid_i(off_rs_valid_i),
        .off_accept_o(off_accept_o), .off_illegal_o(off_illegal_o),
        .commit_go_i(commit_go_i), .kill_i(kill_i),
        .xif_issue_valid_o(xif_issue_valid_o), .xif_issue_ready_i(xif_issue_ready_i),
        .xif_issue_instr_o(xif_issue_instr_o), .xif_issue_id_o(xif_issue_id_o),
        .xif_issue_rs_o(xif_issue_rs_o), .xif_issue_rs_valid_o(xif_issue_rs_valid_o),
        .xif_issue_accept_i(xif_issue_accept_i), .xif_issue_writeback_i(xif_issue_writeback_i),
        .xif_commit_valid_o(xif_commit_valid_o), .xif_commit_id_o(xif_commit_id_o),
        .xif_commit_kill_o(xif_commit_kill_o),
        .xif_result_valid_i(xif_result_valid_i), .xif_result_ready_o(xif_result_ready_o),
        .xif_result_id_i(xif_result_id_i), .xif_result_data_i(xif_result_data_i),
        .xif_result_rd_i(xif_result_rd_i), .xif_result_we_i(xif_result_we_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           kill;
    } cmt_t;

    typedef struct packed {
        logic          we;
        logic [4:0]    addr;
        logic [RW-1:0] data;
    } rf_t;

    cmt_t           cq[$];
    rf_t            rq[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [IDW-1:0] exp_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle inputs, note handshakes, step, check every strobe.
    task automatic tick();
        logic hs_iss, acc, hs_res;
        cmt_t c;
        rf_t  e;
        #1;
        hs_iss = xif_issue_valid_o && xif_issue_ready_i && rst_n;
        acc    = xif_issue_accept_i;
        hs_res = xif_result_valid_i && xif_result_ready_o && rst_n;
        if (hs_iss) chk("issue_id", 64'(xif_issue_id_o), 64'(exp_id));
        @(posedge clk);
        #1;
        chk("off_accept", 64'(off_accept_o), 64'(hs_iss && acc));
        chk("off_illegal", 64'(off_illegal_o), 64'(hs_iss && !acc));
        if (hs_iss) exp_id = exp_id + IDW'(1);
        if (hs_res && rq.size() > 0) begin
            e = rq.pop_front();
            chk("rf_we", 64'(rf_we_o), 64'(e.we));
            if (e.we) begin
                chk("rf_waddr", 64'(rf_waddr_o), 64'(e.addr));
                chk("rf_wdata", 64'(rf_wdata_o), 64'(e.data));
            end
        end else begin
            chk("rf_we_idle", 64'(rf_we_o), 64'd0);
        end
        if (cq.size() > 0) begin
            if (xif_commit_valid_o) begin
                c = cq.pop_front();
                chk("commit_id", 64'(xif_commit_id_o), 64'(c.id));
                chk("commit_kill", 64'(xif_commit_kill_o), 64'(c.kill));
            end
        end else begin
            chk("commit_idle", 64'(xif_commit_valid_o), 64'd0);
        end
    endtask

    task automatic drain_commits(input string tag);
        int n = 0;
        while (cq.size() > 0 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 64'(cq.size()), 64'd0);
    endtask

    // Offload one instruction and complete its issue handshake after 'stall'
    // cycles of issue backpressure.
    task automatic issue_op(input logic [31:0] instr, input logic acc, input logic wb,
                            input int stall);
        logic [NRS*RW-1:0] rs;
        logic [NRS-1:0]    rsv;
        int n = 0;
        rs             = {instr ^ 32'hA5A5_5A5A, ~instr};
        rsv            = instr[1:0];
        off_instr_i    = instr;
        off_rs_i       = rs;
        off_rs_valid_i = rsv;
        off_valid_i    = 1'b1;
        while (!off_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("off_ready_wait", 64'(off_ready_o), 64'd1);
        tick();
        off_valid_i = 1'b0;
        chk("issue_valid", 64'(xif_issue_valid_o), 64'd1);
        chk("issue_instr", 64'(xif_issue_instr_o), 64'(instr));
        chk("issue_rs", 64'(xif_issue_rs_o), 64'(rs));
        chk("issue_rs_valid", 64'(xif_issue_rs_valid_o), 64'(rsv));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("issue_hold_valid", 64'(xif_issue_valid_o), 64'd1);
            chk("issue_hold_instr", 64'(xif_issue_instr_o), 64'(instr));
        end
        xif_issue_ready_i     = 1'b1;
        xif_issue_accept_i    = acc;
        xif_issue_writeback_i = wb;
        tick();
        xif_issue_ready_i     = 1'b0;
        xif_issue_accept_i    = 1'b0;
        xif_issue_writeback_i = 1'b0;
        chk("issue_done", 64'(xif_issue_valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        off_valid_i = 1'b0; off_instr_i = '0; off_rs_i = '0; off_rs_valid_i = '0;
        commit_go_i = 1'b0; kill_i = 1'b0;
        xif_issue_ready_i = 1'b0; xif_issue_accept_i = 1'b0; xif_issue_writeback_i = 1'b0;
        xif_result_valid_i = 1'b0; xif_result_id_i = '0; xif_result_data_i = '0;
        xif_result_rd_i = '0; xif_result_we_i = 1'b0;
        exp_id = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_off_ready", 64'(off_ready_o), 64'd1);
        chk("rst_result_ready", 64'(xif_result_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_issue_valid", 64'(xif_issue_valid_o), 64'd0);
        chk("rst_commit_valid", 64'(xif_commit_valid_o), 64'd0);
        chk("rst_rf_we", 64'(rf_we_o), 64'd0);
        rst_n = 1'b1;

        // Single op: id 0, commit, then result written one cycle later
        issue_op(32'h0000_0033, 1'b1, 1'b1, 0);
        chk("single_busy", 64'(busy_o), 64'd1);
        tick();
        cq.push_back('{id: 4'd0, kill: 1'b0});
        commit_go_i = 1'b1;
        tick();
        commit_go_i = 1'b0;
        chk("single_commit", 64'(cq.size()), 64'd0);
        xif_result_valid_i = 1'b1; xif_result_id_i = 4'd0;
        xif_result_data_i = 32'hDEAD_BEEF; xif_result_rd_i = 5'd5; xif_result_we_i = 1'b1;
        #1;
        chk("single_res_ready", 64'(xif_result_ready_o), 64'd1);
        rq.push_back('{we: 1'b1, addr: 5'd5, data: 32'hDEAD_BEEF});
        tick();
        xif_result_valid_i = 1'b0;
        chk("single_rf_popped", 64'(rq.size()), 64'd0);
        chk("single_idle", 64'(busy_o), 64'd0);

        // Reject: illegal pulse and a kill commit for id 1, no rf write
        cq.push_back('{id: 4'd1, kill: 1'b1});
        issue_op(32'h0000_00B3, 1'b0, 1'b1, 1);
        drain_commits("reject_commit");
        tick();
        chk("reject_idle", 64'(busy_o), 64'd0);

        // id 2 commits without writeback; then ids 3 and 4 are killed
        issue_op(32'h0000_0133, 1'b1, 1'b0, 0);
        cq.push_back('{id: 4'd2, kill: 1'b0});
        commit_go_i = 1'b1;
        tick();
        commit_go_i = 1'b0;
        chk("nowb_idle", 64'(busy_o), 64'd0);
        issue_op(32'h0000_01B3, 1'b1, 1'b1, 0);
        issue_op(32'h0000_0233, 1'b1, 1'b1, 0);
        chk("kill_full", 64'(off_ready_o), 64'd0);
        cq.push_back('{id: 4'd3, kill: 1'b1});
        cq.push_back('{id: 4'd4, kill: 1'b1});
        kill_i = 1'b1; commit_go_i = 1'b1;
        tick();
        kill_i = 1'b0; commit_go_i = 1'b0;
        chk("kill_first", 64'(cq.size()), 64'd1);
        tick();
        chk("kill_second", 64'(cq.size()), 64'd0);
        chk("kill_idle", 64'(busy_o), 64'd0);

        // Early result for uncommitted id 5 is held until after its commit
        issue_op(32'h0000_02B3, 1'b1, 1'b1, 0);
        xif_result_valid_i = 1'b1; xif_result_id_i = 4'd5;
        xif_result_data_i = 32'h1234_5678; xif_result_rd_i = 5'd17; xif_result_we_i = 1'b1;
        #1;
        chk("early_hold0", 64'(xif_result_ready_o), 64'd0);
        tick();
        chk("early_hold1", 64'(xif_result_ready_o), 64'd0);
        cq.push_back('{id: 4'd5, kill: 1'b0});
        commit_go_i = 1'b1;
        #1;
        chk("early_hold_commit", 64'(xif_result_ready_o), 64'd0);
        tick();
        commit_go_i = 1'b0;
        chk("early_commit", 64'(cq.size()), 64'd0);
        chk("early_ready", 64'(xif_result_ready_o), 64'd1);
        rq.push_back('{we: 1'b1, addr: 5'd17, data: 32'h1234_5678});
        tick();
        xif_result_valid_i = 1'b0;
        chk("early_rf_popped", 64'(rq.size()), 64'd0);
        chk("early_idle", 64'(busy_o), 64'd0);

        // Unknown id: accepted and dropped
        xif_result_valid_i = 1'b1; xif_result_id_i = 4'd9; xif_result_we_i = 1'b1;
        #1;
        chk("unknown_ready", 64'(xif_result_ready_o), 64'd1);
        tick();
        xif_result_valid_i = 1'b0;

        // Reset with two outstanding entries
        issue_op(32'h0000_0333, 1'b1, 1'b1, 0);
        issue_op(32'h0000_03B3, 1'b1, 1'b1, 0);
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_off_ready", 64'(off_ready_o), 64'd1);
        chk("mid_rst_commit", 64'(xif_commit_valid_o), 64'd0);
        chk("mid_rst_rf_we", 64'(rf_we_o), 64'd0);
        chk("mid_rst_issue_id", 64'(xif_issue_id_o), 64'd0);
        cq.delete();
        rq.delete();
        exp_id = '0;
        tick();
        rst_n = 1'b1;

        // 20 ops with 3-cycle issue stalls; ids wrap 0..15,0..3
        for (int k = 0; k < 20; k++) begin
            issue_op(32'h0000_0033 | (32'(k) << 7), 1'b1, 1'b0, 3);
            if (k % 2 == 1) begin
                chk("wrap_full_ready", 64'(off_ready_o), 64'd0);
                chk("wrap_full_busy", 64'(busy_o), 64'd1);
                cq.push_back('{id: 4'(k - 1), kill: 1'b0});
                cq.push_back('{id: 4'(k), kill: 1'b0});
                commit_go_i = 1'b1;
                tick();
                tick();
                commit_go_i = 1'b0;
                chk("wrap_commits", 64'(cq.size()), 64'd0);
                chk("wrap_ready_again", 64'(off_ready_o), 64'd1);
            end
        end
        chk("wrap_next_id", 64'(xif_issue_id_o), 64'd4);
        chk("final_busy", 64'(busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
